// File: rtl/rv32i_pkg.sv
// Shared types and opcode constants for the RV32I decode slice.
// The decoded record travels through the skid buffer as one packed word.
package rv32i_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [11:0]     imm12;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } dec_t;

endpackage

// File: rtl/rv32i_decode_if.sv
// Fetch-side and execute-side handshake bundle of the decoder.
// slave is the decoder's view, master is the fetch/execute environment.
interface rv32i_decode_if;
    import rv32i_pkg::*;

    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;

    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [11:0]     imm12;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;

    modport slave (
        input  inst_valid, inst, pc, dec_ready,
        output inst_ready, dec_valid, dec_pc, opcode, funct3, funct7,
               rd, rs1, rs2, imm12, imm, fmt, illegal
    );

    modport master (
        output inst_valid, inst, pc, dec_ready,
        input  inst_ready, dec_valid, dec_pc, opcode, funct3, funct7,
               rd, rs1, rs2, imm12, imm, fmt, illegal
    );

endinterface

// File: rtl/rv32i_imm_gen.sv
// Combinational format classifier and immediate builder for one RV32I word.
// Unknown opcodes and malformed shift-immediates are flagged illegal.
module rv32i_imm_gen
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] inst,
    output fmt_e            fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;

    assign op = inst[6:0];
    assign f3 = inst[14:12];
    assign f7 = inst[31:25];

    always_comb begin
        fmt     = FMT_R;
        illegal = 1'b0;
        unique case (op)
            OP_REG: fmt = FMT_R;
            OP_IMM: begin
                fmt = FMT_I;
                // shamt encodings reuse funct7; only SLLI/SRLI/SRAI patterns exist
                if (f3 == 3'd1 && f7 != 7'h00)
                    illegal = 1'b1;
                else if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)
                    illegal = 1'b1;
            end
            OP_LOAD, OP_JALR, OP_SYSTEM: fmt = FMT_I;
            OP_STORE:                    fmt = FMT_S;
            OP_BRANCH:                   fmt = FMT_B;
            OP_LUI, OP_AUIPC:            fmt = FMT_U;
            OP_JAL:                      fmt = FMT_J;
            default:                     illegal = 1'b1;
        endcase
    end

    always_comb begin
        imm = '0;
        unique case (fmt)
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'h000};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_decode.sv
// Pipelined RV32I decoder: decode ahead of a two-entry skid buffer so fetch
// can stream one word per cycle while execute applies backpressure.
module rv32i_decode
    import rv32i_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    rv32i_decode_if.slave bus
);

    fmt_e            gen_fmt;
    logic [XLEN-1:0] gen_imm;
    logic            gen_illegal;
    dec_t            new_dec;

    dec_t out_reg;
    dec_t skid_reg;
    logic out_valid_reg;
    logic skid_valid_reg;

    logic accept;
    logic consume;

    rv32i_imm_gen u_imm_gen (
        .inst    (bus.inst),
        .fmt     (gen_fmt),
        .imm     (gen_imm),
        .illegal (gen_illegal)
    );

    always_comb begin
        new_dec         = '0;
        new_dec.pc      = bus.pc;
        new_dec.opcode  = bus.inst[6:0];
        new_dec.funct3  = bus.inst[14:12];
        new_dec.funct7  = bus.inst[31:25];
        new_dec.rd      = bus.inst[11:7];
        new_dec.rs1     = bus.inst[19:15];
        new_dec.rs2     = bus.inst[24:20];
        new_dec.imm12   = bus.inst[31:20];
        new_dec.imm     = gen_imm;
        new_dec.fmt     = gen_fmt;
        new_dec.illegal = gen_illegal;
    end

    // Ready depends only on registered state and flush, never on dec_ready.
    assign bus.inst_ready = !skid_valid_reg && !flush;
    assign accept         = bus.inst_valid && bus.inst_ready;
    assign consume        = out_valid_reg && bus.dec_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            out_reg        <= '0;
            skid_reg       <= '0;
        end else if (flush) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (!out_valid_reg || consume) begin
            // Output slot frees up: the older skid entry always goes first.
            if (skid_valid_reg) begin
                out_reg        <= skid_reg;
                skid_valid_reg <= 1'b0;
            end else if (accept) begin
                out_reg       <= new_dec;
                out_valid_reg <= 1'b1;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end else if (accept) begin
            skid_reg       <= new_dec;
            skid_valid_reg <= 1'b1;
        end
    end

    assign bus.dec_valid = out_valid_reg;
    assign bus.dec_pc    = out_reg.pc;
    assign bus.opcode    = out_reg.opcode;
    assign bus.funct3    = out_reg.funct3;
    assign bus.funct7    = out_reg.funct7;
    assign bus.rd        = out_reg.rd;
    assign bus.rs1       = out_reg.rs1;
    assign bus.rs2       = out_reg.rs2;
    assign bus.imm12     = out_reg.imm12;
    assign bus.imm       = out_reg.imm;
    assign bus.fmt       = out_reg.fmt;
    assign bus.illegal   = out_reg.illegal;

endmodule

// File: tb/tb_rv32i_decode.sv
// Randomized bench for rv32i_decode against a FIFO-of-words reference model
// that decodes each word arithmetically when it reaches the head.
module tb_rv32i_decode;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    rv32i_decode_if bus ();

    rv32i_decode dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic [31:0] p;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_deliv  = 0;
    bit   checking = 1'b0;
    bit   rst_prev = 1'b0;
    bit   last_acc = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sext(input int v, input int bits);
        if (v >= (1 << (bits - 1)))
            return v - (1 << bits);
        return v;
    endfunction

    function automatic void ref_dec(input logic [31:0] w, output fmt_e f,
                                    output logic [31:0] im, output bit ill);
        int op = int'(w[6:0]);
        int f3 = int'(w[14:12]);
        int f7 = int'(w[31:25]);
        int v  = 0;
        ill = 1'b0;
        f   = FMT_R;
        im  = 32'd0;
        case (op)
            'h33:                   f = FMT_R;
            'h13, 'h03, 'h67, 'h73: f = FMT_I;
            'h23:                   f = FMT_S;
            'h63:                   f = FMT_B;
            'h37, 'h17:             f = FMT_U;
            'h6F:                   f = FMT_J;
            default:                ill = 1'b1;
        endcase
        if (op == 'h13 && f3 == 1 && f7 != 0) ill = 1'b1;
        if (op == 'h13 && f3 == 5 && f7 != 0 && f7 != 'h20) ill = 1'b1;
        case (f)
            FMT_I: v = sext(int'(w[31:20]), 12);
            FMT_S: v = sext(int'(w[31:25]) * 32 + int'(w[11:7]), 12);
            FMT_B: v = sext(int'(w[31]) * 4096 + int'(w[7]) * 2048
                            + int'(w[30:25]) * 32 + int'(w[11:8]) * 2, 13);
            FMT_U: v = int'(w) - int'(w[11:0]);
            FMT_J: v = sext(int'(w[31]) * (1 << 20) + int'(w[19:12]) * 4096
                            + int'(w[20]) * 2048 + int'(w[30:21]) * 2, 21);
            default: v = 0;
        endcase
        im = v;
    endfunction

    task automatic compare_head(input ent_t e);
        fmt_e        f;
        logic [31:0] im;
        bit          ill;
        ref_dec(e.w, f, im, ill);
        chk("dec_pc",  bus.dec_pc,  e.p);
        chk("opcode",  bus.opcode,  e.w[6:0]);
        chk("funct3",  bus.funct3,  e.w[14:12]);
        chk("funct7",  bus.funct7,  e.w[31:25]);
        chk("rd",      bus.rd,      e.w[11:7]);
        chk("rs1",     bus.rs1,     e.w[19:15]);
        chk("rs2",     bus.rs2,     e.w[24:20]);
        chk("imm12",   bus.imm12,   e.w[31:20]);
        chk("imm",     bus.imm,     im);
        chk("fmt",     bus.fmt,     f);
        chk("illegal", bus.illegal, ill);
    endtask

    // One clock: drive at negedge, check state from the previous edge, advance model.
    task automatic step(input bit v, input logic [31:0] w, input logic [31:0] p,
                        input bit dr, input bit fl, input bit rs);
        bit exp_rdy, acc, cons;
        bus.inst_valid = v;
        bus.inst       = w;
        bus.pc         = p;
        bus.dec_ready  = dr;
        flush          = fl;
        rst            = rs;
        #1;
        exp_rdy = (q.size() < 2) && !fl;
        if (checking) begin
            chk("inst_ready", bus.inst_ready, exp_rdy);
            chk("dec_valid", bus.dec_valid, q.size() > 0);
            if (q.size() > 0) compare_head(q[0]);
            if (rst_prev)
                chk("reset_fields", {bus.opcode, bus.funct3, bus.funct7, bus.rd, bus.rs1,
                                     bus.rs2, bus.imm12, bus.imm, bus.dec_pc, bus.fmt,
                                     bus.illegal}, 128'd0);
        end
        acc  = v && exp_rdy;
        cons = dr && (q.size() > 0);
        @(posedge clk);
        if (rs || fl) begin
            q.delete();
            last_acc = 1'b0;
        end else begin
            if (cons) begin
                void'(q.pop_front());
                n_deliv++;
            end
            if (acc) q.push_back('{w: w, p: p});
            last_acc = acc;
        end
        rst_prev = rs;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73,
                                 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        int          pick = $urandom_range(0, 11);
        logic [31:0] w    = $urandom;
        if (pick < 10) w[6:0] = ops[pick];
        if (w[6:0] == 7'h13 && $urandom_range(0, 1) == 1)
            w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return w;
    endfunction

    initial begin
        logic [31:0] feed [4];
        int          idx;
        int          deliv0;
        int          r;

        @(negedge clk);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        checking = 1'b1;

        // Directed decode cases, each checked one cycle after accept.
        step(1, 32'hFFF10093, 32'h100, 1, 0, 0);
        chk("addi_valid", bus.dec_valid, 1);
        chk("addi_opcode", bus.opcode, 7'h13);
        chk("addi_rd", bus.rd, 5'd1);
        chk("addi_rs1", bus.rs1, 5'd2);
        chk("addi_imm12", bus.imm12, 12'hFFF);
        chk("addi_imm", bus.imm, 32'hFFFFFFFF);
        chk("addi_fmt", bus.fmt, FMT_I);
        step(1, 32'h40335293, 32'h104, 1, 0, 0);
        chk("srai_funct3", bus.funct3, 3'd5);
        chk("srai_imm12", bus.imm12, 12'h403);
        chk("srai_illegal", bus.illegal, 0);
        step(1, 32'h40031293, 32'h108, 1, 0, 0);
        chk("slli_bad_illegal", bus.illegal, 1);
        step(1, 32'h123450B7, 32'h10C, 1, 0, 0);
        chk("lui_fmt", bus.fmt, FMT_U);
        chk("lui_imm", bus.imm, 32'h12345000);
        step(1, 32'h00A00000, 32'h110, 1, 0, 0);
        chk("op0_illegal", bus.illegal, 1);
        chk("op0_fmt", bus.fmt, FMT_R);
        step(0, 0, 0, 1, 0, 0);

        // Backpressure: three stalled cycles accept exactly two words.
        for (int i = 0; i < 4; i++) feed[i] = rand_inst();
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            step(1, feed[idx], 32'h200 + idx * 4, 0, 0, 0);
            if (last_acc) idx++;
        end
        chk("bp_accepted", idx, 2);
        chk("bp_inst_ready", bus.inst_ready, 0);
        deliv0 = n_deliv;
        for (int c = 0; c < 20 && (idx < 4 || q.size() > 0); c++) begin
            step(idx < 4, (idx < 4) ? feed[idx] : 32'd0, 32'h200 + idx * 4, 1, 0, 0);
            if (last_acc) idx++;
        end
        chk("bp_delivered", n_deliv - deliv0, 4);

        // Flush with both entries held and a word on offer.
        step(1, rand_inst(), 32'h300, 0, 0, 0);
        step(1, rand_inst(), 32'h304, 0, 0, 0);
        chk("flush_full_ready", bus.inst_ready, 0);
        step(1, 32'hFFF10093, 32'h308, 0, 1, 0);
        chk("flush_dec_valid", bus.dec_valid, 0);
        flush = 1'b0;
        #1;
        chk("flush_inst_ready", bus.inst_ready, 1);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Reset mid-stream, then resume.
        for (int c = 0; c < 4; c++)
            step(1, rand_inst(), 32'h400 + c * 4, c[0], 0, 0);
        step(1, rand_inst(), 32'h410, 0, 0, 1);
        chk("rst_dec_valid", bus.dec_valid, 0);
        step(1, 32'hFFF10093, 32'h500, 1, 0, 0);
        chk("resume_imm", bus.imm, 32'hFFFFFFFF);
        chk("resume_pc", bus.dec_pc, 32'h500);

        // Random stream with occasional flush and reset.
        for (int c = 0; c < 2000; c++) begin
            r = $urandom_range(0, 99);
            step($urandom_range(0, 9) < 7, rand_inst(), $urandom,
                 $urandom_range(0, 9) < 6, (r < 3), (r == 99));
        end
        step(0, 0, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_decode.md
# rv32i_decode

Pipelined RV32I instruction decoder that sits between instruction fetch and the execute units, including the I-type ALU. It accepts 32-bit instruction words over a valid/ready handshake and splits each word into opcode, funct3, funct7, register indices and a format-correct sign-extended immediate. It flags encodings the execute units do not support. A two-entry skid buffer lets fetch stream one instruction per cycle under execute backpressure without losing or reordering instructions.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `flush`  input  1  synchronous kill of all held instructions, used on branch redirect.
- `inst_valid`  input  1  fetch offers `inst` and `pc`.
- `inst_ready`  output  1  decoder accepts this cycle.
- `inst`  input  32  raw instruction word.
- `pc`  input  32  address of `inst`.
- `dec_valid`  output  1  decoded instruction available.
- `dec_ready`  input  1  execute consumes this cycle.
- `dec_pc`  output  32  pc of the decoded instruction.
- `opcode`  output  7  inst[6:0].
- `funct3`  output  3  inst[14:12].
- `funct7`  output  7  inst[31:25].
- `rd`, `rs1`, `rs2`  output  5 each  inst[11:7], inst[19:15], inst[24:20].
- `imm12`  output  12  raw I-type field inst[31:20], fed to the I-type ALU.
- `imm`  output  32  immediate, sign-extended according to the instruction format.
- `fmt`  output  3  format code from `rv32i_pkg::fmt_e`.
- `illegal`  output  1  encoding is unsupported.

## Operation
- Opcode to format mapping:
  - 0110011 → R.
  - 0010011, 0000011, 1100111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
- Any other opcode sets `illegal`=1 and `fmt`=R. The other field outputs still carry the raw bit slices.
- Immediate construction:
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U: {inst[31:12], 12'h000}.
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - R: imm = 0.
- Shift-immediate legality (opcode 0010011):
  - funct3=1 requires inst[31:25]=7'h00.
  - funct3=5 requires inst[31:25] ∈ {7'h00, 7'h20}.
  - Anything else sets `illegal`.
- Handshakes:
  - A transfer occurs on `inst_valid & inst_ready` and on `dec_valid & dec_ready`.
  - `inst_ready` = !skid_full & !flush.
- Skid buffer:
  - Holds 0, 1 or 2 decoded entries and is strictly FIFO.
  - The output register holds entry 0. The skid register holds an accepted entry only while the output is stalled.
  - Fill level +1 on accept, −1 on consume; accept and consume in the same cycle leave it unchanged.
- `flush`: on the next edge both entries are invalidated. A word offered in the flush cycle is not accepted, because `inst_ready` is 0.
- `rst`: identical effect to `flush`, plus all field outputs are cleared.
- Priority: `rst` > `flush` > handshakes.

## Timing
- Latency: an instruction accepted at edge N is presented with `dec_valid`=1 after edge N, i.e. in cycle N+1.
- Throughput: 1 instruction/cycle while `dec_ready`=1.
- With `dec_ready` held low, at most 2 instructions are accepted; `inst_ready` drops the cycle after the skid fills.
- When `dec_ready` returns high, `inst_ready` rises in the following cycle. No combinational path exists from `dec_ready` to `inst_ready`.
- Outputs are stable while `dec_valid & !dec_ready`.
- Reset values:
  - `dec_valid`=0, `inst_ready`=1 (unless `flush`).
  - All field outputs, `imm`, `imm12` and `dec_pc` = 0.
  - `fmt`=R, `illegal`=0.

## Structure
- `rv32i_pkg`:
  - `fmt_e` enum (FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J).
  - Opcode localparams (OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM).
  - `dec_t` packed struct holding all decoded outputs.
- Sub-module `rv32i_imm_gen`: combinational, inst → {fmt, imm, illegal}. It is instantiated once, ahead of the skid buffer, so the registers store `dec_t`.

## Test plan
- addi x1,x2,-1: 0xFFF10093 → opcode 0x13, rd 1, rs1 2, funct3 0, imm12 0xFFF, imm 0xFFFFFFFF, fmt I, illegal 0, one cycle after accept.
- srai x5,x6,3: 0x40335293 → funct3 5, imm12 0x403, illegal 0. Illegal slli 0x40031293 → illegal 1.
- lui x1,0x12345: 0x123450B7 → fmt U, imm 0x12345000. Opcode 7'b0000000 → illegal 1.
- Backpressure: stream 4 instructions with `dec_ready`=0 for 3 cycles → exactly 2 accepted, `inst_ready`=0, then all 4 delivered in order with no duplicates.
- Flush with 2 entries held while `inst_valid`=1 → next cycle `dec_valid`=0 and `inst_ready`=1; the flush-cycle word is not accepted.
- Assert `rst` mid-stream → next cycle all outputs equal their reset values; decode resumes on the first accept after release.
